// File: rtl/mem_port_arbiter_if.sv
// CPU-side and SRAM-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = CPU + SRAM environment view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  inst_req;
   logic [ADDR_W-1:0]     inst_addr;
   logic                  inst_gnt;
   logic                  inst_rvalid;
   logic [DATA_W-1:0]     inst_rdata;

   logic                  data_req;
   logic                  data_wen;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W/8-1:0]   data_wmask;
   logic                  data_gnt;
   logic                  data_rvalid;
   logic [DATA_W-1:0]     data_rdata;

   logic                  mem_en;
   logic                  mem_wen;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wmask;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wen, data_addr, data_wdata, data_wmask,
      input  mem_rdata,
      output inst_gnt, inst_rvalid, inst_rdata,
      output data_gnt, data_rvalid, data_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wen, data_addr, data_wdata, data_wmask,
      output mem_rdata,
      input  inst_gnt, inst_rvalid, inst_rdata,
      input  data_gnt, data_rvalid, data_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one single-port SRAM between fetch and data ports.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         inst_stall_cnt,
   output logic [31:0]         data_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   logic [3:0] streak_q, streak_d;
   owner_e     owner_q, owner_d;
   logic       inst_gnt, data_gnt;

   // Grants are gated by reset so nothing reaches the SRAM while reset is held.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (reset) begin
         if (bus.data_req && !(bus.inst_req && streak_q == STREAK_MAX)) begin
            data_gnt = 1'b1;
         end else if (bus.inst_req) begin
            inst_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      streak_d = streak_q;
      owner_d  = OWN_NONE;
      if (!bus.inst_req || inst_gnt) begin
         streak_d = 4'd0;
      end else if (data_gnt && streak_q < STREAK_MAX) begin
         streak_d = streak_q + 4'd1;
      end
      if (inst_gnt) begin
         owner_d = OWN_INST;
      end else if (data_gnt && !bus.data_wen) begin
         owner_d = OWN_DATA;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak_q <= 4'd0;
         owner_q  <= OWN_NONE;
      end else begin
         streak_q <= streak_d;
         owner_q  <= owner_d;
      end
   end

   always_comb begin
      bus.mem_en    = inst_gnt | data_gnt;
      bus.mem_wen   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      if (data_gnt) begin
         bus.mem_wen   = bus.data_wen;
         bus.mem_addr  = bus.data_addr;
         bus.mem_wdata = bus.data_wdata;
         bus.mem_wmask = bus.data_wmask;
      end else if (inst_gnt) begin
         bus.mem_addr  = bus.inst_addr;
      end
   end

   assign bus.inst_gnt    = inst_gnt;
   assign bus.data_gnt    = data_gnt;
   assign bus.inst_rvalid = (owner_q == OWN_INST);
   assign bus.data_rvalid = (owner_q == OWN_DATA);
   assign bus.inst_rdata  = (owner_q == OWN_INST) ? bus.mem_rdata : '0;
   assign bus.data_rdata  = (owner_q == OWN_DATA) ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] inst_stall_q, data_stall_q;

   // Counters only observe the grant; they never feed back into arbitration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_stall_q <= 32'd0;
         data_stall_q <= 32'd0;
      end else begin
         if (bus.inst_req && !inst_gnt && inst_stall_q != 32'hFFFF_FFFF) begin
            inst_stall_q <= inst_stall_q + 32'd1;
         end
         if (bus.data_req && !data_gnt && data_stall_q != 32'hFFFF_FFFF) begin
            data_stall_q <= data_stall_q + 32'd1;
         end
      end
   end

   assign inst_stall_cnt = inst_stall_q;
   assign data_stall_cnt = data_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with SRAM model and read-return scoreboard.
// Define ARB_PERF_CNT_EN to also check the stall counters.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MAX_STREAK = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] inst_stall_cnt, data_stall_cnt;
`endif

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(MAX_STREAK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .inst_stall_cnt (inst_stall_cnt),
      .data_stall_cnt (data_stall_cnt)
`endif
   );

   // Synchronous SRAM: byte-masked write, registered read.
   logic [31:0] sram [256];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.mem_wmask[b]) sram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
         end else begin
            bus.mem_rdata <= sram[bus.mem_addr[9:2]];
         end
      end
   end

   // Reference model state
   logic [31:0] shadow [256];
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_data_q[$];
   int          streak_m;
   bit          inst_rv_m, data_rv_m;
   int          inst_stall_m, data_stall_m;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_returns();
      logic [31:0] w;
      chk("inst_rvalid", bus.inst_rvalid, 32'(inst_rv_m));
      if (inst_rv_m && exp_inst_q.size() > 0) begin
         w = exp_inst_q.pop_front();
         chk("inst_rdata", bus.inst_rdata, w);
      end else begin
         chk("inst_rdata_idle", bus.inst_rdata, 32'h0);
      end
      chk("data_rvalid", bus.data_rvalid, 32'(data_rv_m));
      if (data_rv_m && exp_data_q.size() > 0) begin
         w = exp_data_q.pop_front();
         chk("data_rdata", bus.data_rdata, w);
      end else begin
         chk("data_rdata_idle", bus.data_rdata, 32'h0);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_inst_gnt"}, bus.inst_gnt, 32'h0);
      chk({tag, "_data_gnt"}, bus.data_gnt, 32'h0);
      chk({tag, "_mem_en"}, bus.mem_en, 32'h0);
      chk({tag, "_mem_wen"}, bus.mem_wen, 32'h0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      chk({tag, "_inst_rvalid"}, bus.inst_rvalid, 32'h0);
      chk({tag, "_inst_rdata"}, bus.inst_rdata, 32'h0);
      chk({tag, "_data_rvalid"}, bus.data_rvalid, 32'h0);
      chk({tag, "_data_rdata"}, bus.data_rdata, 32'h0);
   endtask

   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm);
      bus.inst_req   = ir;
      bus.inst_addr  = ia;
      bus.data_req   = dr;
      bus.data_wen   = dw;
      bus.data_addr  = da;
      bus.data_wdata = wd;
      bus.data_wmask = wm;
   endtask

   // One arbitration cycle: drive, check returns and grant, update model, advance.
   task automatic do_cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                           input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm);
      bit eg_d, eg_i;
      drive(ir, ia, dr, dw, da, wd, wm);
      #2;
      check_returns();
      eg_d = dr && !(ir && streak_m == MAX_STREAK);
      eg_i = ir && !eg_d;
      chk("inst_gnt", bus.inst_gnt, 32'(eg_i));
      chk("data_gnt", bus.data_gnt, 32'(eg_d));
      chk("gnt_exclusive", 32'(bus.inst_gnt & bus.data_gnt), 32'h0);
      chk("mem_en", bus.mem_en, 32'(eg_i | eg_d));
      chk("mem_wen", bus.mem_wen, 32'(eg_d & dw));
      chk("mem_addr", bus.mem_addr, eg_d ? da : (eg_i ? ia : 32'h0));
      chk("mem_wdata", bus.mem_wdata, eg_d ? wd : 32'h0);
      chk("mem_wmask", 32'(bus.mem_wmask), eg_d ? 32'(wm) : 32'h0);
      if (!ir || eg_i) streak_m = 0;
      else if (eg_d && streak_m < MAX_STREAK) streak_m++;
      if (ir && !eg_i) inst_stall_m++;
      if (dr && !eg_d) data_stall_m++;
      inst_rv_m = eg_i;
      data_rv_m = eg_d && !dw;
      if (eg_i) exp_inst_q.push_back(shadow[ia[9:2]]);
      if (eg_d && !dw) exp_data_q.push_back(shadow[da[9:2]]);
      if (eg_d && dw) begin
         for (int b = 0; b < 4; b++) begin
            if (wm[b]) shadow[da[9:2]][8*b +: 8] = wd[8*b +: 8];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic model_reset();
      streak_m     = 0;
      inst_rv_m    = 1'b0;
      data_rv_m    = 1'b0;
      inst_stall_m = 0;
      data_stall_m = 0;
      exp_inst_q.delete();
      exp_data_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i]   = 32'hA5A5_0000 | 32'(i);
         shadow[i] = 32'hA5A5_0000 | 32'(i);
      end
      sram[0] = 32'h0000_0013;  shadow[0] = 32'h0000_0013;
      sram[1] = 32'h0010_0093;  shadow[1] = 32'h0010_0093;
      sram[2] = 32'h0020_0113;  shadow[2] = 32'h0020_0113;
      model_reset();

      // Reset held with both requests asserted: everything quiet.
      drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      repeat (2) @(posedge clk);
      #3;
      chk_quiet("por");
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Fetch only, three consecutive words.
      do_cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      do_cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      do_cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle();
      idle();

      // Full write, read back, then partial write and read back.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b1111);
      idle();
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h0000_CAFE, 4'b0011);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b1111);
      idle();
      chk("partial_write_word", shadow[64], 32'hDEAD_CAFE);

      // Contention: both held 10 cycles -> D,D,D,D,I,D,D,D,D,I.
      for (int i = 0; i < 10; i++) begin
         do_cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      end
      idle();
`ifdef ARB_PERF_CNT_EN
      chk("inst_stall_cnt", inst_stall_cnt, 32'(inst_stall_m));
      chk("data_stall_cnt", data_stall_cnt, 32'(data_stall_m));
`endif

      // Interleaved returns: inst at N, data read at N+1.
      do_cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      idle();
      idle();

      // Build a streak of 3, then reset in the cycle of a granted data read.
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      end
      drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      #2;
      check_returns();
      chk("rst_read_data_gnt", bus.data_gnt, 32'h1);
      reset = 1'b0;
      #1;
      chk_quiet("rst_async");
      @(posedge clk);
      #1;
      chk_quiet("rst_held");
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #2;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      idle();

      // Streak restarts from zero: four data grants before fetch is forced.
      for (int i = 0; i < 5; i++) begin
         do_cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      end
      idle();
`ifdef ARB_PERF_CNT_EN
      chk("inst_stall_cnt_post_rst", inst_stall_cnt, 32'(inst_stall_m));
      chk("data_stall_cnt_post_rst", data_stall_cnt, 32'(data_stall_m));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch port and data port.
- Sits between the CPU and a unified INST/DATA SRAM on the board.
- Per-cycle grant; data has priority over fetch, with a streak limit so fetch cannot starve.
- Read data returns one cycle after grant and is steered back to the granted requester.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request (read only).
- inst_addr  in  ADDR_W  fetch byte address.
- inst_gnt  out  1  fetch accepted this cycle.
- inst_rvalid  out  1  inst_rdata valid.
- inst_rdata  out  DATA_W  fetched word.
- data_req  in  1  data request.
- data_wen  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  data byte address.
- data_wdata  in  DATA_W  write data.
- data_wmask  in  DATA_W/8  byte write enables.
- data_gnt  out  1  data access accepted this cycle.
- data_rvalid  out  1  data_rdata valid (reads only).
- data_rdata  out  DATA_W  read word.
- mem_en  out  1  SRAM enable.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_wmask  out  DATA_W/8  SRAM byte mask.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read-enabled edge.

Behaviour:
- Grant is combinational from the requests and registered state. At most one grant per cycle.
- A requester holds req and its address/data stable until its gnt is high. A req is a single access; the grant cycle consumes it.
- Priority:
  - data only -> data wins.
  - inst only -> inst wins.
  - both high -> data wins, unless streak_cnt == MAX_DATA_STREAK, then inst wins.
- streak_cnt (4 bit):
  - +1 on each data grant while inst_req is high.
  - Cleared on any inst grant, or on any cycle with inst_req low.
  - Never exceeds MAX_DATA_STREAK.
- SRAM drive:
  - mem_en = inst_gnt | data_gnt.
  - mem_addr/wdata/wmask/wen are muxed from the winner.
  - Inst grant forces mem_wen=0 and mem_wmask=0.
  - With no grant, all mem_* outputs are 0.
- Read return:
  - Register rd_owner (NONE/INST/DATA) at each edge: INST on an inst grant, DATA on a data-read grant, NONE otherwise (including data writes).
  - Next cycle: rd_owner==INST -> inst_rvalid=1, inst_rdata=mem_rdata; rd_owner==DATA -> data_rvalid=1, data_rdata=mem_rdata.
  - rdata is 0 whenever its rvalid is 0.
- Latency:
  - Uncontended: grant in the request cycle, rvalid exactly +1 cycle.
  - Back-to-back grants give one access per cycle; pipelined returns need no bubble.
- Writes: complete at the grant edge; no rvalid. A read of the same address in the next cycle returns the new data (SRAM write-first not required; the following cycle's read must see it).
- Reset low (asynchronous, any cycle):
  - streak_cnt=0, rd_owner=NONE.
  - All rvalid/rdata outputs 0; gnt outputs and mem_en forced 0.
  - A read in flight is dropped, with no rvalid after reset release.
- First cycle after reset rises: normal arbitration.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs inst_stall_cnt[31:0] and data_stall_cnt[31:0].
  - Each counts cycles where its req=1 and gnt=0.
  - Saturate at 0xFFFFFFFF; cleared by reset.
  - Register update has no effect on grant timing.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch only: inst_req=1 at 0x0,0x4,0x8 on consecutive cycles, SRAM preloaded 0x00000013,0x00100093,0x00200113 -> inst_gnt each cycle; inst_rvalid on the following 3 cycles with those words in order.
- Data write then read: write 0xDEADBEEF, mask 4'b1111 to 0x100; next cycle read 0x100 -> data_gnt both cycles; data_rvalid once, one cycle after the read, data_rdata=0xDEADBEEF. Partial write mask 4'b0011 of 0x0000CAFE, then read -> 0xDEADCAFE.
- Contention, MAX_DATA_STREAK=4, both req held high 10 cycles -> grant pattern D,D,D,D,I,D,D,D,D,I; no cycle with both gnts high.
- Reset mid-read: data read granted, reset low before the next edge -> data_rvalid stays 0 through and after reset; streak_cnt=0; all outputs 0 during reset.
- Interleaved returns: inst grant cycle N, data read grant N+1 -> inst_rvalid at N+1, data_rvalid at N+2, no cross-steering of rdata.
- With ARB_PERF_CNT_EN, contention run above -> inst_stall_cnt=8, data_stall_cnt=2.
